// File: rtl/regfile_pkg.sv
// Shared constants and dump FSM encoding for the register file with serial dump.
package regfile_pkg;

    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } dump_state_t;

endpackage

// File: rtl/regfile_core.sv
// 32-entry register file: r0 hardwired to zero, two CPU read ports plus a dump read port,
// optional same-cycle write-to-read forwarding on every read port.
module regfile_core
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    output logic [WIDTH-1:0]  rd3,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd
);

    logic [WIDTH-1:0]  regs [NREGS];
    logic [ADDR_W-1:0] ra_all [3];
    logic [WIDTH-1:0]  rd_all [3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign ra_all[0] = ra1;
    assign ra_all[1] = ra2;
    assign ra_all[2] = ra3;

    // Forwarding check can skip wa!=0 because a zero read address is already forced to 0.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_all[p] = regs[ra_all[p]];
            if (ra_all[p] == '0) begin
                rd_all[p] = '0;
            end else if (BYPASS && we && (wa == ra_all[p])) begin
                rd_all[p] = wd;
            end
        end
    end

    assign rd1 = rd_all[0];
    assign rd2 = rd_all[1];
    assign rd3 = rd_all[2];

endmodule

// File: rtl/regfile_dump.sv
// Register file with a valid/ready serial dump of all 32 registers; the dump never
// stalls the CPU ports, it just uses a dedicated third read port.
//
//   state    | meaning
//   ST_IDLE  | waiting for dump_start
//   ST_FETCH | capture reg[idx] into the output holding register
//   ST_SEND  | dump_valid high, waiting for dump_ready
//   ST_DONE  | one-cycle dump_done pulse after entry 31
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [WIDTH-1:0]  rd1,
    output logic [WIDTH-1:0]  rd2,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [WIDTH-1:0]  wd,
    input  logic              dump_start,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_idx,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_done
);

    dump_state_t       state;
    dump_state_t       state_next;
    logic [ADDR_W-1:0] idx;
    logic [WIDTH-1:0]  rd3;
    logic [WIDTH-1:0]  data_q;
    logic              handshake;

    regfile_core #(
        .WIDTH  (WIDTH),
        .BYPASS (BYPASS)
    ) u_core (
        .clk (clk),
        .rst (rst),
        .ra1 (ra1),
        .ra2 (ra2),
        .ra3 (idx),
        .rd1 (rd1),
        .rd2 (rd2),
        .rd3 (rd3),
        .we  (we),
        .wa  (wa),
        .wd  (wd)
    );

    assign handshake = (state == ST_SEND) && dump_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (dump_start) state_next = ST_FETCH;
            ST_FETCH: state_next = ST_SEND;
            ST_SEND:  if (handshake) state_next = (idx == LAST_IDX) ? ST_DONE : ST_FETCH;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // data_q is only loaded in FETCH, so CPU writes during SEND cannot disturb the entry on offer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            data_q <= '0;
        end else begin
            if ((state == ST_IDLE) && dump_start) begin
                idx <= '0;
            end else if (handshake && (idx != LAST_IDX)) begin
                idx <= idx + ADDR_W'(1);
            end
            if (state == ST_FETCH) begin
                data_q <= rd3;
            end
        end
    end

    always_comb begin
        dump_valid = (state == ST_SEND);
        dump_done  = (state == ST_DONE);
        dump_idx   = idx;
        dump_data  = data_q;
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Scoreboard bench for regfile_dump: a forwarding and a non-forwarding instance share stimulus;
// a behavioural array model predicts reads and dump contents, a negedge monitor checks the dump.
module tb_regfile_dump;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [4:0]   ra1 = '0, ra2 = '0, wa = '0;
    logic         we = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
    logic [W-1:0] wd = '0;

    logic [W-1:0] rd1, rd2, dump_data, rd1_nb, rd2_nb, dump_data_nb;
    logic         dump_valid, dump_done, dump_valid_nb, dump_done_nb;
    logic [4:0]   dump_idx, dump_idx_nb;

    typedef struct {
        logic [4:0]   idx;
        logic [W-1:0] data;
    } entry_t;

    entry_t       exp_q[$];
    logic [W-1:0] model [32];
    int           n_chk = 0, n_err = 0;
    int           popped = 0, n_done = 0, n_valid = 0, exp_dones = 0;
    bit           dump_active = 1'b0;

    regfile_dump #(.WIDTH(W), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .we(we), .wa(wa), .wd(wd), .dump_start(dump_start), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
    );

    regfile_dump #(.WIDTH(W), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
        .we(we), .wa(wa), .wd(wd), .dump_start(dump_start), .dump_valid(dump_valid_nb),
        .dump_ready(dump_ready), .dump_idx(dump_idx_nb), .dump_data(dump_data_nb), .dump_done(dump_done_nb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return '0;
        if (byp && we && (wa == a)) return wd;
        return model[a];
    endfunction

    // One clock cycle of stimulus; a start seen while idle queues the full 32-entry snapshot.
    task automatic step(input logic s_we, input logic [4:0] s_wa, input logic [W-1:0] s_wd,
                        input logic [4:0] s_ra1, input logic [4:0] s_ra2,
                        input logic s_start, input logic s_ready);
        if (s_start && !dump_active) begin
            s_we = 1'b0;
            for (int i = 0; i < 32; i++) exp_q.push_back('{idx: 5'(i), data: model[i]});
            dump_active = 1'b1;
            popped      = 0;
            exp_dones++;
        end
        we = s_we; wa = s_wa; wd = s_wd; ra1 = s_ra1; ra2 = s_ra2;
        dump_start = s_start; dump_ready = s_ready;
        @(negedge clk);
        chk("rd1", rd1, exp_rd(ra1, 1'b1));
        chk("rd2", rd2, exp_rd(ra2, 1'b1));
        chk("rd1_nb", rd1_nb, exp_rd(ra1, 1'b0));
        chk("rd2_nb", rd2_nb, exp_rd(ra2, 1'b0));
        @(posedge clk);
        if (we && (wa != 5'd0)) model[wa] = wd;
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dump_valid) begin
                n_valid++;
                if (exp_q.size() == 0) begin
                    chk("spurious_valid", 32'(dump_valid), 32'd0);
                end else begin
                    chk("dump_idx", 32'(dump_idx), 32'(exp_q[0].idx));
                    chk("dump_data", dump_data, exp_q[0].data);
                    chk("nb_valid", 32'(dump_valid_nb), 32'd1);
                    chk("nb_idx", 32'(dump_idx_nb), 32'(exp_q[0].idx));
                    chk("nb_data", dump_data_nb, exp_q[0].data);
                    if (dump_ready) begin
                        void'(exp_q.pop_front());
                        popped++;
                    end
                end
            end
            if (dump_done) begin
                n_done++;
                chk("done_after_all", 32'(popped), 32'd32);
                chk("done_q_empty", 32'(exp_q.size()), 32'd0);
                chk("done_nb", 32'(dump_done_nb), 32'd1);
                dump_active = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, d0, nv0, found;
        logic [4:0]   s_wa, s_ra1, s_ra2;
        logic         s_we, s_start, s_ready;
        logic [W-1:0] s_wd;

        for (int i = 0; i < 32; i++) model[i] = '0;

        #1 rst = 1'b1;
        #2;
        chk("rst_valid", 32'(dump_valid), 32'd0);
        chk("rst_done", 32'(dump_done), 32'd0);
        chk("rst_idx", 32'(dump_idx), 32'd0);
        chk("rst_data", dump_data, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int a = 0; a < 32; a++) step(1'b0, 5'd0, '0, 5'(a), 5'(31 - a), 1'b0, 1'b0);

        step(1'b1, 5'd0, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b0);
        chk("r0_after_write", rd1, 32'd0);

        we = 1'b1; wa = 5'd5; wd = 32'h12345678; ra1 = 5'd5; ra2 = 5'd0;
        @(negedge clk);
        chk("bypass_same_cycle", rd1, 32'h12345678);
        chk("nobypass_before_edge", rd1_nb, 32'd0);
        @(posedge clk);
        model[5] = 32'h12345678;
        #1 we = 1'b0;
        #1;
        chk("nobypass_after_edge", rd1_nb, 32'h12345678);
        chk("bypass_after_edge", rd1, 32'h12345678);

        // Ordered dump of i*4 with ready held high.
        for (int i = 1; i < 32; i++) step(1'b1, 5'(i), 32'(i * 4), 5'(i), 5'($urandom), 1'b0, 1'b0);
        step(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1);
        d0 = n_done; nv0 = n_valid; found = 0;
        for (k = 1; k <= 200; k++) begin
            step(1'b0, 5'd0, '0, 5'($urandom), 5'($urandom), 1'b0, 1'b1);
            if (n_done > d0) begin found = 1; break; end
        end
        chk("done_cycle", 32'(k), 32'd65);
        chk("valid_cycles", 32'(n_valid - nv0), 32'd32);
        chk("done_found", 32'(found), 32'd1);

        // Hold entry 3 under backpressure while reg[3] is overwritten.
        step(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1);
        for (int t = 0; t < 20 && popped < 3; t++) step(1'b0, 5'd0, '0, 5'd1, 5'd2, 1'b0, 1'b1);
        step(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b0, 1'b0);
        chk("hold_valid", 32'(dump_valid), 32'd1);
        chk("hold_idx", 32'(dump_idx), 32'd3);
        for (int j = 0; j < 5; j++) begin
            step(j == 0, 5'd3, 32'h0000FFFF, 5'd3, 5'd0, 1'b0, 1'b0);
            chk("hold_data", dump_data, 32'd12);
            chk("hold_data_nb", dump_data_nb, 32'd12);
        end
        d0 = n_done;
        for (int t = 0; t < 200 && dump_active; t++) step(1'b0, 5'd0, '0, 5'd3, 5'd0, 1'b0, 1'b1);
        chk("hold_dump_done", 32'(n_done - d0), 32'd1);

        // Reset in the middle of the dump at idx 10.
        step(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b1, 1'b1);
        for (int t = 0; t < 40 && popped < 10; t++) step(1'b0, 5'd0, '0, 5'd9, 5'd10, 1'b0, 1'b1);
        step(1'b0, 5'd0, '0, 5'd10, 5'd0, 1'b0, 1'b0);
        chk("abort_pre_valid", 32'(dump_valid), 32'd1);
        chk("abort_pre_idx", 32'(dump_idx), 32'd10);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 32'(dump_valid), 32'd0);
        chk("abort_valid_nb", 32'(dump_valid_nb), 32'd0);
        chk("abort_done", 32'(dump_done), 32'd0);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a); ra2 = 5'(31 - a);
            #1;
            chk("abort_rd1", rd1, 32'd0);
            chk("abort_rd2_nb", rd2_nb, 32'd0);
        end
        exp_q.delete();
        for (int i = 0; i < 32; i++) model[i] = '0;
        dump_active = 1'b0;
        exp_dones--;
        d0 = n_done; nv0 = n_valid;
        @(posedge clk); #1 rst = 1'b0;
        for (int t = 0; t < 10; t++) step(1'b0, 5'd0, '0, 5'($urandom), 5'($urandom), 1'b0, 1'b1);
        chk("abort_no_done", 32'(n_done), 32'(d0));
        chk("abort_no_valid", 32'(n_valid), 32'(nv0));

        // Random traffic: CPU writes overlap dumps but only touch already-delivered entries.
        for (int c = 0; c < 1500; c++) begin
            s_start = ($urandom % 30) == 0;
            s_ready = ($urandom % 3) != 0;
            s_we    = 1'($urandom);
            if (dump_active) s_wa = (popped == 0) ? 5'd0 : 5'($urandom_range(popped - 1, 0));
            else             s_wa = 5'($urandom);
            s_wd  = $urandom;
            s_ra1 = ($urandom % 2 == 0) ? s_wa : 5'($urandom);
            s_ra2 = ($urandom % 2 == 0) ? s_wa : 5'($urandom);
            step(s_we, s_wa, s_wd, s_ra1, s_ra2, s_start, s_ready);
        end
        for (int t = 0; t < 200 && dump_active; t++) step(1'b0, 5'd0, '0, 5'd0, 5'd0, 1'b0, 1'b1);
        chk("done_count", 32'(n_done), 32'(exp_dones));
        chk("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
REGFILE_DUMP -- requirements
Module: regfile_dump

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of each register.
REQ-002 SHALL have parameter: BYPASS, 1, 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-003 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port: ra1  input  5  read address, port 1 (rs).
REQ-006 SHALL have port: ra2  input  5  read address, port 2 (rt).
REQ-007 SHALL have port: rd1  output  WIDTH  read data, port 1.
REQ-008 SHALL have port: rd2  output  WIDTH  read data, port 2.
REQ-009 SHALL have port: we  input  1  write enable.
REQ-010 SHALL have port: wa  input  5  write address, driven by the 5-bit rt/rd write-register select mux.
REQ-011 SHALL have port: wd  input  WIDTH  write data.
REQ-012 SHALL have port: dump_start  input  1  request a serial dump of all 32 registers.
REQ-013 SHALL have port: dump_valid  output  1  dump_idx/dump_data hold a valid entry.
REQ-014 SHALL have port: dump_ready  input  1  consumer accepts the current entry.
REQ-015 SHALL have port: dump_idx  output  5  register index of the current entry.
REQ-016 SHALL have port: dump_data  output  WIDTH  captured contents of register dump_idx.
REQ-017 SHALL have port: dump_done  output  1  one-cycle pulse after entry 31 is accepted.

Function
REQ-018 SHALL hold 32 registers of WIDTH bits; register 0 reads as 0 always and ignores writes.
REQ-019 SHALL make reads combinational: rdN = reg[raN], zero-latency.
REQ-020 SHALL write wd into reg[wa] on the rising edge when we=1 and wa!=0.
REQ-021 SHALL, when BYPASS=1, we=1, wa!=0 and raN==wa, drive rdN=wd in the same cycle; when BYPASS=0, the old value is read until the edge.
REQ-022 SHALL implement dump FSM states IDLE, FETCH, SEND, DONE.
REQ-023 SHALL transition IDLE->FETCH on dump_start=1, with idx=0; dump_start is ignored outside IDLE.
REQ-024 SHALL, in FETCH (one cycle), capture reg[idx] into dump_data, applying the REQ-021 bypass rule with ra=idx, then go to SEND.
REQ-025 SHALL assert dump_valid only in SEND, holding dump_idx/dump_data stable until dump_valid&dump_ready.
REQ-026 SHALL not change dump_data when a write hits reg[dump_idx] during SEND.
REQ-027 SHALL, on handshake in SEND, go to FETCH with idx+1 if idx<31, else go to DONE; idx does not wrap.
REQ-028 SHALL assert dump_done for exactly the one DONE cycle, then return to IDLE.
REQ-029 SHALL not stall or otherwise affect the CPU read/write ports during a dump.

Reset
REQ-030 SHALL, on rst=1, asynchronously clear all registers to 0, set the FSM to IDLE, and set dump_valid=0, dump_done=0, dump_idx=0, dump_data=0.
REQ-031 SHALL abort a dump in progress on rst assertion mid-dump, with no further dump_valid until a new dump_start after rst deasserts.

Structure
REQ-032 SHALL place the FSM state encoding and constants NREGS=32 and ADDR_W=5 in a shared package, regfile_pkg.
REQ-033 SHALL use one sub-module, regfile_core (storage, read ports, bypass, third read port for the dump); the dump FSM lives in the top module.

Verification
REQ-034 SHALL verify: rst pulse, then read all addresses -> rd1=rd2=0 for every address.
REQ-035 SHALL verify: we=1, wa=0, wd=32'hDEADBEEF -> ra1=0 reads 0.
REQ-036 SHALL verify: BYPASS=1, we=1, wa=5, wd=32'h12345678, ra1=5 in the same cycle -> rd1=32'h12345678 before the edge; with BYPASS=0 -> rd1=0 before the edge, 32'h12345678 after it.
REQ-037 SHALL verify: reg[i]=i*4 preloaded, dump_start, dump_ready=1 always -> 32 entries in order, idx 0..31 with data 0..124, each valid for 1 cycle with a FETCH gap between entries, then a single dump_done pulse.
REQ-038 SHALL verify: dump at idx=3 (data 12), dump_ready=0 for 5 cycles while writing reg[3]=32'hFFFF -> dump_data stays 12 until the handshake.
REQ-039 SHALL verify: rst asserted at idx=10 -> dump_valid=0 and all registers 0 immediately; no dump_done.
